// File: rtl/mant_div48by24.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor.
// One quotient bit per clock, start/done handshake, overflow and divide-by-zero flags.
module mant_div48by24 #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   R,
  output logic               ovf,
  output logic               dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state;
  // Stored remainder is always < divisor, so WIDTH bits suffice between steps;
  // the WIDTH+1-bit partial remainder exists only as 'shifted' below.
  logic [WIDTH-1:0]   p;
  // Low dividend half shifts out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   b_reg;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH-1:0]   p_next;
  logic [WIDTH-1:0]   q_next;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    shifted = {p, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_reg});
    // When ge holds the difference is < divisor, so its MSB is always zero.
    diff    = WIDTH'(shifted - {1'b0, b_reg});
    p_next  = ge ? diff : shifted[WIDTH-1:0];
    q_next  = {lo[WIDTH-2:0], ge};
  end

  // Control FSM with registered outputs; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      lo    <= '0;
      b_reg <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
            b_reg <= B;
            if (B == '0) begin
              dbz   <= 1'b1;
              Q     <= '1;
              R     <= A[WIDTH-1:0];
              state <= FIN;
            end else if (A[2*WIDTH-1:WIDTH] >= B) begin
              // Quotient would need more than WIDTH bits.
              ovf   <= 1'b1;
              Q     <= '1;
              R     <= '0;
              state <= FIN;
            end else begin
              p     <= A[2*WIDTH-1:WIDTH];
              lo    <= A[WIDTH-1:0];
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= p_next;
          lo  <= q_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            Q     <= q_next;
            R     <= p_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_div48by24.sv
// Directed + invariant-checking bench for the 48/24 restoring divider.
module tb_mant_div48by24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] A;
  logic [23:0] B;
  logic        busy, done, ovf, dbz;
  logic [23:0] Q, R;

  int n_checks = 0;
  int n_fail   = 0;

  mant_div48by24 #(.WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] a;
    logic [23:0] b;
    logic [23:0] q;
    logic [23:0] r;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE; returns cycles from accepting edge to done (cap 40).
  task automatic do_op(input logic [47:0] a, input logic [23:0] b,
                       output int lat, output logic busy_acc);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  initial begin
    int lat;
    logic bacc;
    int pulses;
    logic [23:0] q_s, r_s;
    logic [47:0] ra, prod;
    logic [23:0] rb;

    vecs[0] = '{48'h400000_000000, 24'h800000, 24'h800000, 24'h000000, 1'b0, 1'b0, 24};
    vecs[1] = '{48'h000000_000064, 24'h000007, 24'h00000E, 24'h000002, 1'b0, 1'b0, 24};
    vecs[2] = '{48'h800000_000000, 24'h800000, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1};
    vecs[3] = '{48'h000000_ABCDEF, 24'h000000, 24'hFFFFFF, 24'hABCDEF, 1'b0, 1'b1, 1};
    vecs[4] = '{48'h000001_000000, 24'h000003, 24'h555555, 24'h000001, 1'b0, 1'b0, 24};
    vecs[5] = '{48'h7FFFFF_FFFFFF, 24'h800000, 24'hFFFFFF, 24'h7FFFFF, 1'b0, 1'b0, 24};
    vecs[6] = '{48'hFFFFFE_FFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b0, 1'b0, 24};
    vecs[7] = '{48'hFFFFFF_000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1};
    vecs[8] = '{48'h000000_000000, 24'h000001, 24'h000000, 24'h000000, 1'b0, 1'b0, 24};
    vecs[9] = '{48'h123456_789ABC, 24'h000000, 24'hFFFFFF, 24'h789ABC, 1'b0, 1'b1, 1};

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset Q", 64'(Q), 64'd0);
    check("reset R", 64'(R), 64'd0);
    check("reset flags", 64'({ovf, dbz}), 64'd0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, bacc);
      check($sformatf("vec%0d busy", i), 64'(bacc), 64'd1);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d Q", i), 64'(Q), 64'(vecs[i].q));
      check($sformatf("vec%0d R", i), 64'(R), 64'(vecs[i].r));
      check($sformatf("vec%0d ovf/dbz", i), 64'({ovf, dbz}), 64'({vecs[i].ovf, vecs[i].dbz}));
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse", i), 64'({done, busy}), 64'd0);
      check($sformatf("vec%0d hold Q", i), 64'(Q), 64'(vecs[i].q));
    end

    // start while busy is ignored
    A = 48'h000000_000064; B = 24'h000007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; lat = 0; q_s = '0; r_s = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin A = 48'h000010_000000; B = 24'h000123; start = 1'b1; end
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin pulses++; lat = c; q_s = Q; r_s = R; end
    end
    check("ignore pulses", 64'(pulses), 64'd1);
    check("ignore latency", 64'(lat), 64'd24);
    check("ignore Q", 64'(q_s), 64'h00000E);
    check("ignore R", 64'(r_s), 64'h000002);

    // reset in the middle of CALC
    A = 48'h000000_000064; B = 24'h000007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy/done", 64'({busy, done}), 64'd0);
    check("abort Q", 64'(Q), 64'd0);
    check("abort R", 64'(R), 64'd0);
    pulses = 0;
    repeat (30) begin @(posedge clk); #1; if (done) pulses++; end
    check("abort no done", 64'(pulses), 64'd0);
    do_op(48'h000001_000000, 24'h000003, lat, bacc);
    check("post-abort latency", 64'(lat), 64'd24);
    check("post-abort Q", 64'(Q), 64'h555555);
    check("post-abort R", 64'(R), 64'h000001);

    // back-to-back: start held through done
    A = 48'h000001_000000; B = 24'h000003; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 40);
    check("b2b first latency", 64'(lat), 64'd24);
    check("b2b first Q", 64'(Q), 64'h555555);
    A = 48'h000000_000064; B = 24'h000007;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accept", 64'({busy, done}), 64'b10);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!done && lat < 40);
    check("b2b second latency", 64'(lat), 64'd24);
    check("b2b second Q", 64'(Q), 64'h00000E);
    check("b2b second R", 64'(R), 64'h000002);

    // random regression on the division invariant
    for (int k = 0; k < 300; k++) begin
      rb = 24'($urandom_range(1, 24'hFFFFFF));
      ra = {24'($urandom % rb), 24'($urandom)};
      do_op(ra, rb, lat, bacc);
      prod = 48'(Q) * 48'(rb) + 48'(R);
      check($sformatf("rand%0d A==Q*B+R", k), 64'(prod), 64'(ra));
      check($sformatf("rand%0d R<B", k), 64'(R < rb), 64'd1);
      check($sformatf("rand%0d flags", k), 64'({lat == 24, ovf, dbz}), 64'b100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
